// File: rtl/herring_clock_controller.sv
// herring_clock_controller
//   Generates the 6502 PHI2 clock from clk_src with a programmable half-period.
//   When stretching is enabled, the PHI2-high phase is extended by wait states
//   for accesses to ROM and to the ACIA/VIA IO region. Firmware changes the
//   speed at run time through one config register in the FPGA window.
//
//   state   | meaning
//   --------+-----------------------------------------------------------
//   LOW     | PHI2 low for h_act cycles; region/rw latched on exit
//   HIGH    | PHI2 high for h_act cycles
//   STRETCH | PHI2 high for WAIT extra cycles of the latched region
//
// Ports
//   clk_src        source clock; all logic runs on its rising edge
//   rst            synchronous reset, active high
//   address        CPU address[15:10]
//   rw             CPU RWB (1 = read)
//   data_in        CPU data bus, used for config writes
//   cpu_clk_in     registered PHI2 to the CPU
//   data_out       config register readback
//   data_oe        drive data_out onto the CPU bus
//   stretch_active high during wait-state cycles
//   phi2_fall      one-cycle pulse on each PHI2 high-to-low transition
module herring_clock_controller #(
  parameter int unsigned DIV_DEFAULT = 8,
  parameter int unsigned WAIT_ROM    = 2,
  parameter int unsigned WAIT_IO     = 4
) (
  input  logic       clk_src,
  input  logic       rst,
  input  logic [5:0] address,
  input  logic       rw,
  input  logic [7:0] data_in,
  output logic       cpu_clk_in,
  output logic [7:0] data_out,
  output logic       data_oe,
  output logic       stretch_active,
  output logic       phi2_fall
);

  typedef enum logic [1:0] {ST_LOW, ST_HIGH, ST_STRETCH} state_t;
  typedef enum logic [1:0] {RGN_OTHER, RGN_ROM, RGN_IO, RGN_FPGA} region_t;

  localparam logic [4:0] H_RESET    = 5'(DIV_DEFAULT / 2);
  localparam logic [7:0] CFG_RESET  = {1'b1, 2'b00, H_RESET};
  localparam logic [4:0] WAIT_ROM_L = 5'(WAIT_ROM);
  localparam logic [4:0] WAIT_IO_L  = 5'(WAIT_IO);

  state_t      state, state_next;
  region_t     region_dec, region_lat;
  logic        rw_lat;
  logic [4:0]  phase_cnt, wait_cnt, h_act, wait_len;
  logic [7:0]  cfg, cfg_wr, cfg_next;
  logic        rise, fall, commit;
  logic        unused_data_bits;

  // bits [6:5] of a config write have no storage; they always read back as 0
  assign unused_data_bits = ^data_in[6:5];

  always_comb begin
    region_dec = RGN_OTHER;
    if (address[5:3] == 3'b111)        region_dec = RGN_ROM;
    else if (address[5:1] == 5'b10000) region_dec = RGN_IO;
    else if (address == 6'b100011)     region_dec = RGN_FPGA;
  end

  // wait_len is zero for any region that is never stretched
  always_comb begin
    wait_len = '0;
    if (region_lat == RGN_ROM)     wait_len = WAIT_ROM_L;
    else if (region_lat == RGN_IO) wait_len = WAIT_IO_L;
  end

  // a half-period below 2 cannot produce a valid PHI2 phase
  assign cfg_wr = {data_in[7], 2'b00, (data_in[4:0] < 5'd2) ? 5'd2 : data_in[4:0]};

  always_comb begin
    state_next = state;
    rise       = 1'b0;
    fall       = 1'b0;
    case (state)
      ST_LOW: begin
        if (phase_cnt == h_act - 5'd1) begin
          state_next = ST_HIGH;
          rise       = 1'b1;
        end
      end
      ST_HIGH: begin
        if (phase_cnt == h_act - 5'd1) begin
          if (cfg[7] && (wait_len != '0)) begin
            state_next = ST_STRETCH;
          end else begin
            state_next = ST_LOW;
            fall       = 1'b1;
          end
        end
      end
      ST_STRETCH: begin
        if (wait_cnt == wait_len - 5'd1) begin
          state_next = ST_LOW;
          fall       = 1'b1;
        end
      end
      default: state_next = ST_LOW;
    endcase
    commit   = fall && (region_lat == RGN_FPGA) && !rw_lat;
    cfg_next = commit ? cfg_wr : cfg;
  end

  assign data_out       = cfg;
  assign stretch_active = (state == ST_STRETCH);
  assign data_oe        = (state != ST_LOW) && (region_lat == RGN_FPGA) && rw_lat;

  always_ff @(posedge clk_src) begin
    if (rst) state <= ST_LOW;
    else     state <= state_next;
  end

  always_ff @(posedge clk_src) begin
    if (rst) begin
      phase_cnt  <= '0;
      wait_cnt   <= '0;
      h_act      <= H_RESET;
      cfg        <= CFG_RESET;
      region_lat <= RGN_OTHER;
      rw_lat     <= 1'b1;
      cpu_clk_in <= 1'b0;
      phi2_fall  <= 1'b0;
    end else begin
      cpu_clk_in <= (state_next != ST_LOW);
      phi2_fall  <= fall;
      cfg        <= cfg_next;
      // phase counter holds during STRETCH so it never runs past h_act-1
      if (state_next != state)      phase_cnt <= '0;
      else if (state != ST_STRETCH) phase_cnt <= phase_cnt + 5'd1;
      if ((state == ST_STRETCH) && (state_next == ST_STRETCH)) wait_cnt <= wait_cnt + 5'd1;
      else                                                     wait_cnt <= '0;
      if (rise) begin
        region_lat <= region_dec;
        rw_lat     <= rw;
      end
      // the LOW phase that starts on a commit edge already uses the new H
      if (fall) h_act <= cfg_next[4:0];
    end
  end

endmodule
